// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32 pipeline front end.
//   XLEN      : datapath / address width
//   NOP_INST  : canonical bubble instruction (addi x0, x0, 0)
//   OPC_*     : RV32I major opcodes used by decode
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
//   req    : fetch request (master -> memory)
//   addr   : word-aligned fetch address (master -> memory)
//   gnt    : request accepted this cycle (memory -> master)
//   rvalid : response valid, responses return in request order (memory -> master)
//   rdata  : instruction word (memory -> master)
interface fetch_stage_if #(
  parameter int XLEN = fetch_stage_pkg::XLEN
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : write an entry (accepted when not full, or full and popping)
//   pop, rdata    : rdata is the head entry; pop removes it when non-empty
//   clear         : empty the FIFO; wins over push and pop
//   count, empty, full : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count guards every read, so stale
  // contents are never observed and the array maps onto plain registers/RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the five-stage RV32 pipeline.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   imem              : instruction-memory bus (fetch_stage_if.master)
//   redirect_i/_pc_i  : taken branch/jump from execute and its target
//   flush_i           : kill the instruction presented to decode
//   stall_i           : hold the outputs (load-use hazard)
//   pc_o/inst_o/valid_o : pc/instruction pair registered by decode
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched_o (kept responses) and
// perf_stall_o (cycles with stall_i && valid_o); both wrap.
module fetch_stage #(
  parameter int              XLEN      = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fetch_stage_if.master    imem,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  inst_o,
  output logic             valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]  perf_fetched_o,
  output logic [XLEN-1:0]  perf_stall_o
`endif
);

  import fetch_stage_pkg::*;

  localparam int              CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [XLEN-1:0] NOP   = XLEN'(NOP_INST);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]  pc_q;        // next fetch address
  logic [XLEN-1:0]  pc_resp_q;   // PC belonging to the next kept response
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] drop_q;      // responses still owed from before a redirect
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   in_flight;
  logic             buf_empty, buf_full;
  entry_t           buf_head, rsp_entry;
  logic             issue, rsp, keep, advance, fall_through, buf_push, buf_pop;

  // Requests are capped so every kept response always finds a buffer slot,
  // even if decode stalls indefinitely.
  assign in_flight = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem.req  = rst_ni && !redirect_i && (in_flight < (CNT_W+1)'(BUF_DEPTH));
  assign imem.addr = pc_q;

  assign issue     = imem.req && imem.gnt;
  assign rsp       = imem.rvalid && (outstanding_q != '0);
  assign keep      = rsp && (drop_q == '0) && !redirect_i;
  assign rsp_entry = '{pc: pc_resp_q, inst: imem.rdata};

  // A kept response goes straight to decode only when nothing older waits.
  assign advance      = !redirect_i && !flush_i && !stall_i;
  assign buf_pop      = advance && !buf_empty;
  assign fall_through = advance && buf_empty && keep;
  assign buf_push     = keep && !fall_through;

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (buf_push),
    .pop    (buf_pop),
    .clear  (redirect_i),
    .wdata  (rsp_entry),
    .rdata  (buf_head),
    .count  (buf_count),
    .empty  (buf_empty),
    .full   (buf_full)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      pc_resp_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      if (redirect_i) begin
        pc_q      <= redirect_pc_i;
        pc_resp_q <= redirect_pc_i;
      end else begin
        if (issue) pc_q      <= pc_q + XLEN'(4);
        if (keep)  pc_resp_q <= pc_resp_q + XLEN'(4);
      end

      outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(rsp);

      // Everything still in flight at a redirect is stale, including a
      // response landing in the redirect cycle itself.
      if (redirect_i)
        drop_q <= outstanding_q - CNT_W'(rsp);
      else if (rsp && (drop_q != '0))
        drop_q <= drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_o    <= '0;
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end else if (redirect_i || flush_i) begin
      pc_o    <= '0;
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end else if (stall_i) begin
      // hold the presented instruction
    end else if (!buf_empty) begin
      pc_o    <= buf_head.pc;
      inst_o  <= buf_head.inst;
      valid_o <= 1'b1;
    end else if (keep) begin
      pc_o    <= rsp_entry.pc;
      inst_o  <= rsp_entry.inst;
      valid_o <= 1'b1;
    end else begin
      pc_o    <= '0;
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (keep)               perf_fetched_o <= perf_fetched_o + XLEN'(1);
      if (stall_i && valid_o) perf_stall_o   <= perf_stall_o + XLEN'(1);
    end
  end
`endif

  // An unrequested response is ignored by the logic above but flags a broken
  // memory model.
  a_no_spurious_rvalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem.rvalid |-> (outstanding_q != '0));

  // The request cap must leave room for every pushed entry.
  a_buf_room : assert property (
    @(posedge clk_i) disable iff (!rst_ni) buf_push |-> (!buf_full || buf_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A memory model answers requests in
// order with random latency (data = addr ^ 32'hA5A5_0000); a reference model
// built from queues predicts req/addr and the decode-side outputs each cycle.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mem_req_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic        flush    = 1'b0;
  logic        stall    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, inst;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem          (imem),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .flush_i       (flush),
    .stall_i       (stall),
    .pc_o          (pc),
    .inst_o        (inst),
    .valid_o       (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_stall_o   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  mem_req_t    mem_q[$];     // granted requests not yet answered
  logic [31:0] avail_q[$];   // fetched addresses not yet presented to decode
  logic [31:0] m_fetch_pc;
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  int unsigned m_fetched, m_stalled;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0;
    m_pc    = '0;
    m_inst  = NOP_INST;
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stalled);
`endif
  endtask

  // Called at a negedge; returns two negedges later with reset released.
  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    #1;
    mem_q.delete();
    avail_q.delete();
    m_fetch_pc = RST_PC;
    model_bubble();
    m_fetched = 0;
    m_stalled = 0;
    check("rst_req", imem.req, 1'b0);
    check("rst_addr", imem.addr, RST_PC);
    check("rst_pc", pc, '0);
    check("rst_inst", inst, NOP_INST);
    check("rst_valid", valid, 1'b0);
    check_perf();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, model the posedge, check after it.
  task automatic cycle(input bit st, input bit fl, input bit rd, input logic [31:0] tgt,
                       input int gnt_pct, input int rv_pct);
    bit       rv_now, gnt_now, exp_req;
    mem_req_t rsp;
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = tgt;
    rv_now      = (mem_q.size() != 0) && ($urandom_range(0, 99) < rv_pct);
    imem.rvalid = rv_now;
    imem.rdata  = rv_now ? (mem_q[0].addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    exp_req = !rd && ((mem_q.size() + avail_q.size()) < DEPTH);
    check("req", imem.req, exp_req);
    if (exp_req) check("addr", imem.addr, m_fetch_pc);
    gnt_now  = imem.req && ($urandom_range(0, 99) < gnt_pct);
    imem.gnt = gnt_now;

    @(posedge clk);
    if (st && m_valid) m_stalled++;
    if (rd) foreach (mem_q[i]) mem_q[i].stale = 1'b1;
    if (rv_now) begin
      rsp = mem_q.pop_front();
      if (!rsp.stale) begin
        avail_q.push_back(rsp.addr);
        m_fetched++;
      end
    end
    if (gnt_now) begin
      mem_q.push_back('{addr: m_fetch_pc, stale: 1'b0});
      m_fetch_pc += 32'd4;
    end
    if (rd) begin
      m_fetch_pc = tgt;
      avail_q.delete();
    end
    if (rd || fl) begin
      model_bubble();
    end else if (!st) begin
      if (avail_q.size() != 0) begin
        m_pc    = avail_q.pop_front();
        m_inst  = m_pc ^ KEY;
        m_valid = 1'b1;
      end else begin
        model_bubble();
      end
    end
    #1;
    check("valid", valid, m_valid);
    check("pc", pc, m_pc);
    check("inst", inst, m_inst);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int gnt_pct, input int rv_pct);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, gnt_pct, rv_pct);
  endtask

  initial begin
    bit          r_st, r_fl, r_rd;
    logic [31:0] r_tgt;

    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    @(negedge clk);
    do_reset();

    // Steady stream: first instruction reaches decode two edges after release,
    // then one per cycle.
    run(12, 100, 100);
    check_perf();

    // Long stall in a steady stream: outputs frozen, request cap reached.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0, 100, 100);
    check("stall_req_low", imem.req, 1'b0);
    run(6, 100, 100);

    // Redirect with two requests outstanding; both late responses are stale.
    do_reset();
    run(2, 100, 0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 100, 0);
    run(8, 100, 100);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    run(1, 100, 0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 0, 100);
    run(6, 100, 100);

    // Flush while stalled, then the next instruction follows.
    run(4, 100, 100);
    cycle(1'b1, 1'b0, 1'b0, '0, 100, 100);
    cycle(1'b1, 1'b1, 1'b0, '0, 100, 100);
    run(5, 100, 100);

    // Grant withheld for three cycles: address must stay stable.
    run(3, 0, 100);
    run(6, 100, 100);
    check_perf();

    // Address wrap-around at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 100, 100);
    run(8, 100, 100);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        check_perf();
        do_reset();
      end
      r_st  = ($urandom_range(0, 99) < 25);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_rd  = ($urandom_range(0, 99) < 4);
      r_tgt = $urandom & 32'hFFFF_FFFC;
      cycle(r_st, r_fl, r_rd, r_tgt, 70, 70);
    end
    run(8, 100, 100);
    check_perf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
